mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences and shares the single main-memory port between two requesters: the instruction fetch unit (IFU) and the load/store unit (LSU).
- Fixed priority goes to the LSU. A starvation counter guarantees that the IFU makes forward progress.
- Runs one transaction at a time with a request/grant/valid handshake on each side and a command/valid handshake toward memory.
- Sits between the IFU/LSU and the memory interface in the core top level.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width for read and write data.
- STARVE_LIMIT, 4, number of consecutive lost arbitrations after which a pending IFU request wins over the LSU.
- TIMEOUT_CYCLES, 64, number of busy cycles without mem_valid_in before the transaction is aborted (used only with the optional feature).

Ports:
- clock_in  input  1  single clock; every flop is clocked on the rising edge.
- reset_in  input  1  synchronous, active-high reset.
- ifu_req_in  input  1  IFU read request; held high until ifu_valid_out.
- ifu_addr_in  input  ADDR_W  IFU fetch address.
- ifu_grant_out  output  1  high while the IFU transaction is in flight.
- ifu_valid_out  output  1  one-cycle pulse: ifu_data_out is valid.
- ifu_data_out  output  DATA_W  registered fetch data.
- lsu_req_in  input  1  LSU request; held high until lsu_valid_out.
- lsu_we_in  input  1  1 = write, 0 = read.
- lsu_addr_in  input  ADDR_W  LSU address.
- lsu_wdata_in  input  DATA_W  LSU write data.
- lsu_grant_out  output  1  high while the LSU transaction is in flight.
- lsu_valid_out  output  1  one-cycle pulse: read data valid, or write done.
- lsu_data_out  output  DATA_W  registered load data.
- mem_addr_out  output  ADDR_W  latched transaction address.
- mem_wdata_out  output  DATA_W  latched write data.
- mem_read_out  output  1  read command, level, held until completion.
- mem_write_out  output  1  write command, level, held until completion.
- mem_rdata_in  input  DATA_W  memory read data, sampled when mem_valid_in is high.
- mem_valid_in  input  1  memory completion strobe.
- mem_timeout_out  output  1  one-cycle abort pulse (tied 0 without the optional feature).

Behaviour:
- **Reset values.** Reset applies to every output, counter and data register:
  - State = IDLE.
  - All grant, valid, command and timeout outputs are 0.
  - All data and address outputs are 0.
  - The starvation counter and the timeout counter are 0.
- **States.** IDLE, BUSY_IFU, BUSY_LSU, DONE.
- **IDLE arbitration.** Evaluated at each clock edge while in IDLE:
  - If lsu_req_in = 1 and NOT (ifu_req_in = 1 and starve_cnt >= STARVE_LIMIT): go to BUSY_LSU.
  - Otherwise, if ifu_req_in = 1: go to BUSY_IFU.
  - Otherwise: stay in IDLE.
- **Latching on grant.** On entry to a BUSY state, the registers latch:
  - the address;
  - the write data and the write-enable (LSU only).
  - Changes to requester inputs after the grant are ignored.
- **Starvation counter.**
  - Increments (saturating at STARVE_LIMIT) on each IDLE arbitration in which ifu_req_in = 1 and the LSU wins.
  - Clears whenever the IFU is granted.
- **BUSY state outputs.**
  - The requester's grant output is 1.
  - mem_read_out = 1 (IFU, or LSU read), or mem_write_out = 1 (LSU write).
  - mem_addr_out and mem_wdata_out are driven from the latched registers.
- **Completion.** When mem_valid_in = 1 is sampled in a BUSY state:
  - capture mem_rdata_in into the requester's data_out; an LSU write leaves lsu_data_out unchanged;
  - go to DONE.
- **DONE.** Lasts exactly one cycle:
  - the requester's valid_out = 1;
  - grant, mem_read_out and mem_write_out are 0;
  - next state is IDLE.
- **Latency.**
  - Request seen at edge 0 → command high from cycle 1.
  - mem_valid_in sampled at edge k → valid_out high during cycle k+1.
  - Next arbitration at edge k+2.
  - Best case is 3 cycles per transaction.
- **Ignored inputs.**
  - mem_valid_in outside a BUSY state is ignored.
  - Dropping req mid-transaction has no effect; the transaction completes and valid still pulses.
- **Data hold.** data_out registers hold their last value until the next completion for that requester.
- **Reset mid-transaction.** The transaction is abandoned, no valid pulse is produced, and all outputs go to their reset values on the next edge.

Optional Feature:
- Macro MEM_PORT_ARBITER_TIMEOUT_EN.
- **Defined:**
  - A timeout counter clears on BUSY entry and increments each BUSY cycle without mem_valid_in.
  - When it reaches TIMEOUT_CYCLES-1 without mem_valid_in, go to DONE with the following outputs:
    - the requester's valid_out pulses;
    - the requester's data_out is loaded with 0;
    - mem_timeout_out pulses together with valid_out.
  - mem_valid_in arriving on that same cycle wins: normal completion, no timeout.
- **Undefined:**
  - No counter exists, and BUSY waits indefinitely.
  - mem_timeout_out is tied 0.

Test Plan:
- **IFU read.** ifu_req=1, addr 0x00000010, mem_valid 2 cycles after the command with rdata 0xDEADBEEF.
  - Expected: ifu_grant and mem_read high for 2 cycles, mem_addr=0x10.
  - Then ifu_valid pulses 1 cycle with ifu_data=0xDEADBEEF, and lsu outputs stay 0.
- **LSU write.** lsu_req=1, we=1, addr 0x20, wdata 0x12345678, mem_valid on the first busy cycle.
  - Expected: mem_write=1, mem_wdata=0x12345678, lsu_valid pulses, lsu_data unchanged.
- **Simultaneous requests, LSU priority.** Both requests held, memory always responds in 1 cycle, STARVE_LIMIT=4.
  - Expected grant sequence: LSU, LSU, LSU, LSU, IFU, LSU, and so on.
- **Request withdrawal.** ifu_req is dropped the cycle after grant and the address is changed to 0x40.
  - Expected: the transaction completes at the original address, and ifu_valid still pulses.
- **Reset mid-BUSY.** reset_in=1 asserted while in BUSY_LSU.
  - Expected: next cycle all outputs are 0, no lsu_valid pulse, and arbitration restarts cleanly after reset is released.
- **Timeout (with macro, TIMEOUT_CYCLES=8).** mem_valid is never asserted.
  - Expected: after 8 busy cycles, mem_timeout_out and ifu_valid pulse together, ifu_data=0, then return to IDLE.
  - Without the macro, the arbiter stays busy and mem_timeout_out stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares the single main-memory port between the instruction
//             fetch unit (IFU) and the load/store unit (LSU). The LSU has
//             fixed priority, and a starvation counter lets a pending IFU
//             request win after STARVE_LIMIT consecutive lost arbitrations.
//             One transaction is in flight at a time:
//             IDLE -> BUSY_IFU/BUSY_LSU -> DONE -> IDLE.
//  Optional : `define MEM_PORT_ARBITER_TIMEOUT_EN enables a busy-cycle
//             watchdog that aborts a transaction after TIMEOUT_CYCLES cycles
//             without mem_valid_in. When it is undefined, mem_timeout_out is
//             tied 0.
//  Ports    :
//    clock_in, reset_in          rising-edge clock, sync active-high reset
//    ifu_req_in/ifu_addr_in      IFU read request and address
//    ifu_grant_out               IFU transaction in flight
//    ifu_valid_out/ifu_data_out  one-cycle completion pulse, held fetch data
//    lsu_req_in/lsu_we_in        LSU request, 1 = write
//    lsu_addr_in/lsu_wdata_in    LSU address and write data
//    lsu_grant_out               LSU transaction in flight
//    lsu_valid_out/lsu_data_out  one-cycle completion pulse, held load data
//    mem_addr_out/mem_wdata_out  latched transaction address and write data
//    mem_read_out/mem_write_out  level command, held until completion
//    mem_rdata_in/mem_valid_in   memory read data and completion strobe
//    mem_timeout_out             one-cycle abort pulse
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clock_in,
   input  logic              reset_in,
   input  logic              ifu_req_in,
   input  logic [ADDR_W-1:0] ifu_addr_in,
   output logic              ifu_grant_out,
   output logic              ifu_valid_out,
   output logic [DATA_W-1:0] ifu_data_out,
   input  logic              lsu_req_in,
   input  logic              lsu_we_in,
   input  logic [ADDR_W-1:0] lsu_addr_in,
   input  logic [DATA_W-1:0] lsu_wdata_in,
   output logic              lsu_grant_out,
   output logic              lsu_valid_out,
   output logic [DATA_W-1:0] lsu_data_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [DATA_W-1:0] mem_wdata_out,
   output logic              mem_read_out,
   output logic              mem_write_out,
   input  logic [DATA_W-1:0] mem_rdata_in,
   input  logic              mem_valid_in,
   output logic              mem_timeout_out
);

   localparam int               CNT_W        = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_BUSY_IFU = 2'd1,
      ST_BUSY_LSU = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_we;
   logic              r_owner_lsu;   // which requester owns the DONE pulse
   logic [CNT_W-1:0]  r_starve_cnt;
   logic [DATA_W-1:0] r_ifu_data;
   logic [DATA_W-1:0] r_lsu_data;
   logic              w_ifu_starved;
   logic              w_take_lsu;
   logic              w_take_ifu;
   logic              w_complete;
   logic              w_timeout_hit;
   logic              w_to_expired;
   logic              w_busy;

   assign w_busy = (r_state == ST_BUSY_IFU) || (r_state == ST_BUSY_LSU);

   // ------------------------------------------------------------------------
   // Optional busy watchdog
   // ------------------------------------------------------------------------
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
   localparam int              TO_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] r_to_cnt;
   logic            r_timed_out;

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         r_to_cnt    <= '0;
         r_timed_out <= 1'b0;
      end else begin
         if (w_take_lsu || w_take_ifu) begin
            r_to_cnt <= '0;
         end else if (w_busy && !mem_valid_in) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end
         // Flag lives exactly for the DONE cycle that follows the abort.
         r_timed_out <= w_timeout_hit;
      end
   end

   assign w_to_expired = (r_to_cnt == C_TO_LAST);
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
   assign w_to_expired     = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_take_lsu      = 1'b0;
      w_take_ifu      = 1'b0;
      w_complete      = 1'b0;
      w_timeout_hit   = 1'b0;
      w_ifu_starved   = ifu_req_in && (r_starve_cnt >= C_STARVE_MAX);
      ifu_grant_out   = 1'b0;
      lsu_grant_out   = 1'b0;
      ifu_valid_out   = 1'b0;
      lsu_valid_out   = 1'b0;
      mem_read_out    = 1'b0;
      mem_write_out   = 1'b0;
      mem_timeout_out = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (lsu_req_in && !w_ifu_starved) begin
               w_state_nxt = ST_BUSY_LSU;
               w_take_lsu  = 1'b1;
            end else if (ifu_req_in) begin
               w_state_nxt = ST_BUSY_IFU;
               w_take_ifu  = 1'b1;
            end
         end
         ST_BUSY_IFU, ST_BUSY_LSU: begin
            ifu_grant_out = (r_state == ST_BUSY_IFU);
            lsu_grant_out = (r_state == ST_BUSY_LSU);
            mem_read_out  = (r_state == ST_BUSY_IFU) || !r_we;
            mem_write_out = (r_state == ST_BUSY_LSU) && r_we;
            // A completion on the expiry cycle takes precedence over abort.
            if (mem_valid_in) begin
               w_state_nxt = ST_DONE;
               w_complete  = 1'b1;
            end else if (w_to_expired) begin
               w_state_nxt   = ST_DONE;
               w_timeout_hit = 1'b1;
            end
         end
         ST_DONE: begin
            ifu_valid_out = !r_owner_lsu;
            lsu_valid_out = r_owner_lsu;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
            mem_timeout_out = r_timed_out;
`endif
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Grant-time latches, starvation counter and read-data registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         r_addr       <= '0;
         r_wdata      <= '0;
         r_we         <= 1'b0;
         r_owner_lsu  <= 1'b0;
         r_starve_cnt <= '0;
         r_ifu_data   <= '0;
         r_lsu_data   <= '0;
      end else begin
         if (w_take_lsu) begin
            r_addr      <= lsu_addr_in;
            r_wdata     <= lsu_wdata_in;
            r_we        <= lsu_we_in;
            r_owner_lsu <= 1'b1;
            // The IFU only counts as having lost if it was actually asking.
            if (ifu_req_in && (r_starve_cnt != C_STARVE_MAX)) begin
               r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
         end
         if (w_take_ifu) begin
            r_addr       <= ifu_addr_in;
            r_we         <= 1'b0;
            r_owner_lsu  <= 1'b0;
            r_starve_cnt <= '0;
         end
         if (w_complete) begin
            if (!r_owner_lsu) begin
               r_ifu_data <= mem_rdata_in;
            end else if (!r_we) begin
               r_lsu_data <= mem_rdata_in;
            end
         end
         if (w_timeout_hit) begin
            if (r_owner_lsu) begin
               r_lsu_data <= '0;
            end else begin
               r_ifu_data <= '0;
            end
         end
      end
   end

   assign mem_addr_out  = r_addr;
   assign mem_wdata_out = r_wdata;
   assign ifu_data_out  = r_ifu_data;
   assign lsu_data_out  = r_lsu_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. Directed scenarios
//             (IFU read, LSU write, priority/starvation, withdrawal, reset
//             mid-transaction, stalled memory) followed by randomized traffic,
//             all compared every cycle against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int STARVE_LIMIT   = 4;
   localparam int TIMEOUT_CYCLES = 8;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
   localparam bit C_TO_EN = 1'b1;
`else
   localparam bit C_TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req;
   logic [31:0] ifu_addr;
   logic        ifu_grant;
   logic        ifu_valid;
   logic [31:0] ifu_data;
   logic        lsu_req;
   logic        lsu_we;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic        lsu_grant;
   logic        lsu_valid;
   logic [31:0] lsu_data;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_rdata;
   logic        mem_valid;
   logic        mem_timeout;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .STARVE_LIMIT   (STARVE_LIMIT),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clock_in        (clk),
      .reset_in        (rst),
      .ifu_req_in      (ifu_req),
      .ifu_addr_in     (ifu_addr),
      .ifu_grant_out   (ifu_grant),
      .ifu_valid_out   (ifu_valid),
      .ifu_data_out    (ifu_data),
      .lsu_req_in      (lsu_req),
      .lsu_we_in       (lsu_we),
      .lsu_addr_in     (lsu_addr),
      .lsu_wdata_in    (lsu_wdata),
      .lsu_grant_out   (lsu_grant),
      .lsu_valid_out   (lsu_valid),
      .lsu_data_out    (lsu_data),
      .mem_addr_out    (mem_addr),
      .mem_wdata_out   (mem_wdata),
      .mem_read_out    (mem_read),
      .mem_write_out   (mem_write),
      .mem_rdata_in    (mem_rdata),
      .mem_valid_in    (mem_valid),
      .mem_timeout_out (mem_timeout)
   );

   // ------------------------------------------------------------------------
   // Transaction-level reference: who owns the port, what was latched, how
   // long the memory has been silent, how often the IFU has lost.
   // ------------------------------------------------------------------------
   bit          m_busy, m_done, m_lsu, m_we, m_to;
   logic [31:0] m_addr, m_wdata, m_ifu_data, m_lsu_data;
   int          m_lost, m_wait;

   task automatic model_edge();
      if (rst) begin
         m_busy = 0; m_done = 0; m_lsu = 0; m_we = 0; m_to = 0;
         m_addr = 0; m_wdata = 0; m_ifu_data = 0; m_lsu_data = 0;
         m_lost = 0; m_wait = 0;
      end else if (m_done) begin
         m_done = 0;
         m_to   = 0;
      end else if (m_busy) begin
         if (mem_valid) begin
            if (!m_lsu)     m_ifu_data = mem_rdata;
            else if (!m_we) m_lsu_data = mem_rdata;
            m_busy = 0;
            m_done = 1;
         end else if (C_TO_EN && (m_wait == TIMEOUT_CYCLES - 1)) begin
            if (m_lsu) m_lsu_data = 0;
            else       m_ifu_data = 0;
            m_busy = 0;
            m_done = 1;
            m_to   = 1;
         end else begin
            m_wait++;
         end
      end else begin
         if (lsu_req && !(ifu_req && m_lost >= STARVE_LIMIT)) begin
            m_busy = 1; m_lsu = 1; m_we = lsu_we;
            m_addr = lsu_addr; m_wdata = lsu_wdata; m_wait = 0;
            if (ifu_req && m_lost < STARVE_LIMIT) m_lost++;
         end else if (ifu_req) begin
            m_busy = 1; m_lsu = 0; m_we = 0;
            m_addr = ifu_addr; m_wait = 0; m_lost = 0;
         end
      end
   endtask

   task automatic check_value(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      check_value("ifu_grant", 32'(ifu_grant),   32'(m_busy && !m_lsu));
      check_value("lsu_grant", 32'(lsu_grant),   32'(m_busy && m_lsu));
      check_value("mem_read",  32'(mem_read),    32'(m_busy && !(m_lsu && m_we)));
      check_value("mem_write", 32'(mem_write),   32'(m_busy && m_lsu && m_we));
      check_value("ifu_valid", 32'(ifu_valid),   32'(m_done && !m_lsu));
      check_value("lsu_valid", 32'(lsu_valid),   32'(m_done && m_lsu));
      check_value("timeout",   32'(mem_timeout), 32'(m_done && m_to));
      check_value("ifu_data",  ifu_data, m_ifu_data);
      check_value("lsu_data",  lsu_data, m_lsu_data);
      if (m_busy) check_value("mem_addr", mem_addr, m_addr);
      if (m_busy && m_lsu && m_we) check_value("mem_wdata", mem_wdata, m_wdata);
   endtask

   // Inputs only ever change at posedge+1, so model and DUT see the same
   // values at each rising edge.
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) begin
         mem_valid = m_busy;
         mem_rdata = $urandom;
         cyc();
      end
      mem_valid = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   bit order [10];
   int n_grants;
   bit prev_any;

   initial begin
      rst = 1; ifu_req = 0; ifu_addr = 0; lsu_req = 0; lsu_we = 0;
      lsu_addr = 0; lsu_wdata = 0; mem_rdata = 0; mem_valid = 0;

      // Reset state
      cyc(); cyc();
      check_value("rst_addr",  mem_addr, 32'h0);
      check_value("rst_wdata", mem_wdata, 32'h0);
      rst = 0;

      // IFU read, memory answers on the second busy cycle
      ifu_req = 1; ifu_addr = 32'h10;
      cyc();
      check_value("ifurd_grant1", 32'(ifu_grant), 32'd1);
      check_value("ifurd_addr",   mem_addr, 32'h10);
      cyc();
      check_value("ifurd_read2",  32'(mem_read), 32'd1);
      mem_valid = 1; mem_rdata = 32'hDEADBEEF;
      cyc();
      check_value("ifurd_valid",  32'(ifu_valid), 32'd1);
      check_value("ifurd_data",   ifu_data, 32'hDEADBEEF);
      check_value("ifurd_lsuval", 32'(lsu_valid), 32'd0);
      ifu_req = 0; mem_valid = 0;
      cyc();
      check_value("ifurd_pulse",  32'(ifu_valid), 32'd0);
      check_value("ifurd_hold",   ifu_data, 32'hDEADBEEF);

      // LSU write, completion on the first busy cycle
      lsu_req = 1; lsu_we = 1; lsu_addr = 32'h20; lsu_wdata = 32'h12345678;
      cyc();
      check_value("lsuwr_write", 32'(mem_write), 32'd1);
      check_value("lsuwr_wdata", mem_wdata, 32'h12345678);
      mem_valid = 1; mem_rdata = 32'hCAFEF00D;
      cyc();
      check_value("lsuwr_valid", 32'(lsu_valid), 32'd1);
      check_value("lsuwr_data",  lsu_data, 32'h0);
      lsu_req = 0; lsu_we = 0; mem_valid = 0;
      cyc();

      // Both requesting, one-cycle memory: L L L L I L L L L I
      ifu_req = 1; lsu_req = 1; ifu_addr = 32'h1000; lsu_addr = 32'h2000;
      n_grants = 0; prev_any = 0;
      for (int i = 0; i < 30; i++) begin
         mem_valid = m_busy;
         mem_rdata = $urandom;
         cyc();
         if ((ifu_grant || lsu_grant) && !prev_any && n_grants < 10) begin
            order[n_grants] = ifu_grant;
            n_grants++;
         end
         prev_any = ifu_grant || lsu_grant;
      end
      check_value("prio_count", n_grants, 10);
      for (int i = 0; i < 10; i++)
         check_value($sformatf("prio_is_ifu_%0d", i), 32'(order[i]), 32'((i == 4) || (i == 9)));
      ifu_req = 0; lsu_req = 0;
      drain(4);

      // Request withdrawn and address changed after the grant
      ifu_req = 1; ifu_addr = 32'h100;
      cyc();
      ifu_req = 0; ifu_addr = 32'h40;
      cyc();
      check_value("wd_addr",  mem_addr, 32'h100);
      check_value("wd_grant", 32'(ifu_grant), 32'd1);
      mem_valid = 1; mem_rdata = 32'h5A5A1234;
      cyc();
      check_value("wd_valid", 32'(ifu_valid), 32'd1);
      check_value("wd_data",  ifu_data, 32'h5A5A1234);
      mem_valid = 0;
      cyc();

      // Reset while the LSU owns the port
      lsu_req = 1; lsu_we = 0; lsu_addr = 32'h44;
      cyc();
      check_value("rb_grant", 32'(lsu_grant), 32'd1);
      rst = 1; mem_valid = 1; mem_rdata = 32'h77;
      cyc();
      check_value("rb_lsugrant", 32'(lsu_grant), 32'd0);
      check_value("rb_lsuvalid", 32'(lsu_valid), 32'd0);
      check_value("rb_read",     32'(mem_read), 32'd0);
      check_value("rb_addr",     mem_addr, 32'h0);
      check_value("rb_ifudata",  ifu_data, 32'h0);
      rst = 0; mem_valid = 0;
      cyc();
      check_value("rb_regrant", 32'(lsu_grant), 32'd1);
      check_value("rb_readdr",  mem_addr, 32'h44);
      mem_valid = 1; mem_rdata = 32'h13579BDF;
      cyc();
      check_value("rb_valid", 32'(lsu_valid), 32'd1);
      check_value("rb_data",  lsu_data, 32'h13579BDF);
      lsu_req = 0; mem_valid = 0;
      cyc();

      // Silent memory: abort with the watchdog, otherwise wait forever
      ifu_req = 1; ifu_addr = 32'h50; mem_valid = 0;
      for (int i = 0; i < 12; i++) cyc();
      ifu_req = 0;
      drain(4);

      // Randomized traffic
      for (int i = 0; i < 700; i++) begin
         if (m_done && !m_lsu)                        ifu_req = 0;
         else if (!ifu_req && $urandom_range(0, 2) == 0) ifu_req = 1;
         if (m_done && m_lsu)                         lsu_req = 0;
         else if (!lsu_req && $urandom_range(0, 2) == 0) lsu_req = 1;
         if ($urandom_range(0, 29) == 0) ifu_req = 0;
         ifu_addr  = $urandom;
         lsu_addr  = $urandom;
         lsu_wdata = $urandom;
         lsu_we    = 1'($urandom_range(0, 1));
         mem_valid = ($urandom_range(0, 9) < 4);
         mem_rdata = $urandom;
         rst       = ($urandom_range(0, 199) == 0);
         cyc();
      end
      rst = 0; ifu_req = 0; lsu_req = 0;
      drain(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
